// File: rtl/fv_ex_queue.sv
// In-flight instruction tracking queue for the formal property checker.
// Records issued tags and kill expectations, matches DUT kills, and exposes per-commit-slot status.
module fv_ex_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_COMMIT = 2,
  parameter int unsigned TAG_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enq_valid,
  input  logic [TAG_W-1:0]             enq_tag,
  input  logic                         enq_expect_kill,
  input  logic                         ex_kill,
  input  logic [TAG_W-1:0]             ex_kill_tag,
  input  logic [MAX_COMMIT:1]          commit,
  output logic [MAX_COMMIT:1]          ex_queue_is_empty,
  output logic [MAX_COMMIT:1]          no_uncommitted_instr,
  output logic [MAX_COMMIT:1]          check_committed_instr,
  output logic [MAX_COMMIT:1]          expected_kill,
  output logic [MAX_COMMIT:1]          received_kill,
  output logic                         killed_instr_found,
  output logic                         ex_queue_is_full,
  output logic                         ex_queue_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d, ek_q, ek_d, rk_q, rk_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic             overflow_q, overflow_d;

  logic [PTR_W-1:0] ord_idx [DEPTH];
  logic             kill_hit;
  logic [PTR_W-1:0] kill_idx;
  logic [CNT_W-1:0] slot_off [1:MAX_COMMIT];
  logic [PTR_W-1:0] slot_idx [1:MAX_COMMIT];
  logic [MAX_COMMIT:1] slot_has;
  logic [CNT_W-1:0] pops;
  logic [CNT_W-1:0] cnt_after_pop;
  logic             enq_ok;

  // Entry index of the k-th oldest element.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord_idx[k] = head_q + PTR_W'(k);
    end
  end

  // Oldest-first search for an unkilled entry carrying the kill tag.
  always_comb begin
    kill_hit = 1'b0;
    kill_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!kill_hit && ex_kill && (CNT_W'(k) < count_q) && valid_q[ord_idx[k]] &&
          !rk_q[ord_idx[k]] && (tag_q[ord_idx[k]] == ex_kill_tag)) begin
        kill_hit = 1'b1;
        kill_idx = ord_idx[k];
      end
    end
  end

  // Slot i is compacted onto the entry after all lower-numbered strobed slots.
  always_comb begin
    logic [CNT_W-1:0] off;
    off  = '0;
    pops = '0;
    for (int i = 1; i <= MAX_COMMIT; i++) begin
      slot_off[i] = off;
      slot_idx[i] = head_q + PTR_W'(off);
      slot_has[i] = (off < count_q);
      if (commit[i] && slot_has[i]) pops = pops + 1'b1;
      if (commit[i]) off = off + 1'b1;
    end
  end

  always_comb begin
    ex_queue_is_empty     = '1;
    no_uncommitted_instr  = '1;
    check_committed_instr = '0;
    expected_kill         = '0;
    received_kill         = '0;
    for (int i = 1; i <= MAX_COMMIT; i++) begin
      ex_queue_is_empty[i]     = !slot_has[i];
      check_committed_instr[i] = commit[i] && slot_has[i];
      if (slot_has[i]) begin
        expected_kill[i] = ek_q[slot_idx[i]];
        received_kill[i] = rk_q[slot_idx[i]] || (kill_hit && (kill_idx == slot_idx[i]));
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CNT_W'(k) >= slot_off[i]) && (CNT_W'(k) < count_q) &&
            !(rk_q[ord_idx[k]] || (kill_hit && (kill_idx == ord_idx[k])))) begin
          no_uncommitted_instr[i] = 1'b0;
        end
      end
    end
  end

  // Next state: kill marking, then pops, then the enqueue (may reuse a just-vacated entry).
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    ek_d       = ek_q;
    rk_d       = rk_q;
    tag_d      = tag_q;
    overflow_d = overflow_q;

    if (kill_hit) rk_d[kill_idx] = 1'b1;

    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < pops) valid_d[ord_idx[k]] = 1'b0;
    end
    head_d = head_q + PTR_W'(pops);

    cnt_after_pop = count_q - pops;
    enq_ok        = enq_valid && (cnt_after_pop < CNT_W'(DEPTH));
    if (enq_ok) begin
      valid_d[tail_q] = 1'b1;
      tag_d[tail_q]   = enq_tag;
      ek_d[tail_q]    = enq_expect_kill;
      rk_d[tail_q]    = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    if (enq_valid && !enq_ok) overflow_d = 1'b1;

    count_d = cnt_after_pop + CNT_W'(enq_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      ek_q       <= '0;
      rk_q       <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      ek_q       <= ek_d;
      rk_q       <= rk_d;
      overflow_q <= overflow_d;
      tag_q      <= tag_d;
    end
  end

  assign killed_instr_found = kill_hit;
  assign ex_queue_is_full   = (count_q == CNT_W'(DEPTH));
  assign ex_queue_overflow  = overflow_q;
  assign count              = count_q;

endmodule

// File: tb/tb_fv_ex_queue.sv
// Directed bench for fv_ex_queue: linear steps with hand-computed expectations.
module tb_fv_ex_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       enq_valid;
  logic [7:0] enq_tag;
  logic       enq_expect_kill;
  logic       ex_kill;
  logic [7:0] ex_kill_tag;
  logic [2:1] commit;
  logic [2:1] ex_queue_is_empty, no_uncommitted_instr, check_committed_instr;
  logic [2:1] expected_kill, received_kill;
  logic       killed_instr_found, ex_queue_is_full, ex_queue_overflow;
  logic [3:0] count;

  int vecs = 0;
  int fails = 0;

  fv_ex_queue #(.DEPTH(8), .MAX_COMMIT(2), .TAG_W(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enq_valid             (enq_valid),
    .enq_tag               (enq_tag),
    .enq_expect_kill       (enq_expect_kill),
    .ex_kill               (ex_kill),
    .ex_kill_tag           (ex_kill_tag),
    .commit                (commit),
    .ex_queue_is_empty     (ex_queue_is_empty),
    .no_uncommitted_instr  (no_uncommitted_instr),
    .check_committed_instr (check_committed_instr),
    .expected_kill         (expected_kill),
    .received_kill         (received_kill),
    .killed_instr_found    (killed_instr_found),
    .ex_queue_is_full      (ex_queue_is_full),
    .ex_queue_overflow     (ex_queue_overflow),
    .count                 (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance one edge, clear all strobes, and settle mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    enq_valid = 1'b0; enq_expect_kill = 1'b0; ex_kill = 1'b0; commit = 2'b00;
    #1;
  endtask

  task automatic enq(input logic [7:0] t, input logic ek);
    enq_valid = 1'b1; enq_tag = t; enq_expect_kill = ek;
    tick();
  endtask

  initial begin
    reset = 1'b1; enq_valid = 1'b0; enq_tag = '0; enq_expect_kill = 1'b0;
    ex_kill = 1'b0; ex_kill_tag = '0; commit = 2'b00;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(ex_queue_is_empty), 32'h3);
    chk("rst_nouncommit", 32'(no_uncommitted_instr), 32'h3);
    chk("rst_check", 32'(check_committed_instr), 0);
    chk("rst_full", 32'(ex_queue_is_full), 0);
    chk("rst_ovf", 32'(ex_queue_overflow), 0);

    // Basic enqueue and double commit
    enq(8'd1, 1'b0); enq(8'd2, 1'b0); enq(8'd3, 1'b0);
    chk("t1_count3", 32'(count), 3);
    chk("t1_empty", 32'(ex_queue_is_empty), 0);
    commit = 2'b11; #1;
    chk("t1_check11", 32'(check_committed_instr), 32'h3);
    tick();
    chk("t1_count1", 32'(count), 1);
    ex_kill = 1'b1; ex_kill_tag = 8'd1; #1;
    chk("t1_kill_popped", 32'(killed_instr_found), 0);
    ex_kill_tag = 8'd3; #1;
    chk("t1_kill_head3", 32'(killed_instr_found), 1);
    tick();
    commit = 2'b01; #1;
    chk("t1_rk_head", 32'(received_kill), 32'h1);
    chk("t1_empty_slot2", 32'(ex_queue_is_empty), 32'h2);
    chk("t1_check01", 32'(check_committed_instr), 32'h1);
    tick();
    chk("t1_count0", 32'(count), 0);

    // Expected kill then received kill
    enq(8'd5, 1'b1);
    ex_kill = 1'b1; ex_kill_tag = 8'd5; #1;
    chk("t2_kill_found", 32'(killed_instr_found), 1);
    tick();
    commit = 2'b01; #1;
    chk("t2_ek", 32'(expected_kill), 32'h1);
    chk("t2_rk", 32'(received_kill), 32'h1);
    chk("t2_nouncommit", 32'(no_uncommitted_instr), 32'h3);
    tick();

    // Full, overflow, and enqueue-with-pop while full
    for (int n = 0; n < 8; n++) enq(8'(8'd10 + n), 1'b0);
    chk("t3_full", 32'(ex_queue_is_full), 1);
    chk("t3_count8", 32'(count), 8);
    enq(8'd18, 1'b0);
    chk("t3_ovf", 32'(ex_queue_overflow), 1);
    chk("t3_count_drop", 32'(count), 8);
    enq_valid = 1'b1; enq_tag = 8'd19; commit = 2'b01; #1;
    chk("t3_check_full", 32'(check_committed_instr), 32'h1);
    tick();
    chk("t3_count_swap", 32'(count), 8);
    chk("t3_ovf_sticky", 32'(ex_queue_overflow), 1);
    commit = 2'b10; #1;
    chk("t3_noncontig_check", 32'(check_committed_instr), 32'h2);
    chk("t3_noncontig_empty", 32'(ex_queue_is_empty), 0);
    tick();
    chk("t3_count7", 32'(count), 7);
    for (int n = 0; n < 3; n++) begin commit = 2'b11; tick(); end
    chk("t3_count1", 32'(count), 1);
    commit = 2'b11; #1;
    chk("t3_last_check", 32'(check_committed_instr), 32'h1);
    tick();
    chk("t3_drained", 32'(count), 0);
    commit = 2'b11; #1;
    chk("t3_commit_empty", 32'(ex_queue_is_empty), 32'h3);
    chk("t3_commit_empty_chk", 32'(check_committed_instr), 0);
    tick();
    chk("t3_still0", 32'(count), 0);

    // Pointer wrap: each cycle enqueue the next tag and commit the head
    enq(8'h20, 1'b0);
    for (int n = 0; n < 20; n++) begin
      enq_valid = 1'b1; enq_tag = 8'(8'h21 + n); commit = 2'b01;
      ex_kill = 1'b1; ex_kill_tag = 8'(8'h20 + n); #1;
      chk("t4_fifo_kill", 32'(killed_instr_found), 1);
      chk("t4_fifo_rk", 32'(received_kill), 32'h1);
      tick();
      chk("t4_count", 32'(count <= 4'd2), 1);
    end
    chk("t4_count_end", 32'(count), 1);
    enq_valid = 1'b1; enq_tag = 8'h40; ex_kill = 1'b1; ex_kill_tag = 8'h40; #1;
    chk("t4_kill_new_entry", 32'(killed_instr_found), 0);
    tick();
    ex_kill = 1'b1; ex_kill_tag = 8'h40; #1;
    chk("t4_kill_next_cycle", 32'(killed_instr_found), 1);
    tick();
    chk("t4_nouncommit00", 32'(no_uncommitted_instr), 0);
    commit = 2'b01; #1;
    chk("t4_nouncommit01", 32'(no_uncommitted_instr), 32'h2);
    tick();
    commit = 2'b01; tick();
    chk("t4_count0", 32'(count), 0);

    // Kill and commit same entry; unmatched kill; duplicate tags
    enq(8'd9, 1'b0);
    ex_kill = 1'b1; ex_kill_tag = 8'd9; commit = 2'b01; #1;
    chk("t5_bypass_rk", 32'(received_kill), 32'h1);
    chk("t5_bypass_found", 32'(killed_instr_found), 1);
    tick();
    chk("t5_count0", 32'(count), 0);
    ex_kill = 1'b1; ex_kill_tag = 8'h7F; #1;
    chk("t5_nomatch", 32'(killed_instr_found), 0);
    tick();
    enq(8'd7, 1'b0); enq(8'd7, 1'b1);
    ex_kill = 1'b1; ex_kill_tag = 8'd7; tick();
    ex_kill = 1'b1; ex_kill_tag = 8'd7; #1;
    chk("t5_dup_second", 32'(killed_instr_found), 1);
    ex_kill = 1'b0; commit = 2'b11; #1;
    chk("t5_dup_rk", 32'(received_kill), 32'h1);
    chk("t5_dup_ek", 32'(expected_kill), 32'h2);
    tick();

    // Reset mid-operation beats concurrent enqueue/commit
    for (int n = 0; n < 4; n++) enq(8'(8'h50 + n), 1'b0);
    enq(8'h60, 1'b0); enq(8'h61, 1'b0); enq(8'h62, 1'b0); enq(8'h63, 1'b0);
    enq(8'h64, 1'b0);
    chk("t6_pre_ovf", 32'(ex_queue_overflow), 1);
    reset = 1'b1; enq_valid = 1'b1; enq_tag = 8'h70; commit = 2'b11;
    ex_kill = 1'b1; ex_kill_tag = 8'h50;
    tick();
    reset = 1'b0; #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(ex_queue_is_empty), 32'h3);
    chk("t6_nouncommit", 32'(no_uncommitted_instr), 32'h3);
    chk("t6_ovf", 32'(ex_queue_overflow), 0);
    chk("t6_full", 32'(ex_queue_is_full), 0);
    chk("t6_found", 32'(killed_instr_found), 0);
    chk("t6_ek_rk", 32'({expected_kill, received_kill}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
